rdmx_write_responder: RTL and testbench
=======================================

Name: rdmx_write_responder

Overview:
- AXI4 write-slave at the receive end of the RDMX link.
- Accepts one AW burst at a time, consumes its W beats, forwards them on an AXI-Stream master (burst start address on TUSER), then returns a B response.
- Checks burst framing and reports errors through BRESP and a sticky error flag.
- Feeds the RDMX-to-PCI receive path.

Parameters:
- DW, 512, data width in bits (TDATA/WDATA); DW/8 byte lanes.
- AW, 64, address width.
- IW, 4, AXI ID width.
- UW, 32, AWUSER width.

Ports:
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  synchronous active-low reset
- S_AXI_AWADDR  in  AW  burst start address
- S_AXI_AWUSER  in  UW  per-burst user field
- S_AXI_AWLEN  in  8  beats minus 1
- S_AXI_AWSIZE  in  3  beat size; must equal log2(DW/8)
- S_AXI_AWBURST  in  2  must be INCR (2'b01)
- S_AXI_AWID  in  IW  transaction ID
- S_AXI_AWVALID  in  1  address valid
- S_AXI_AWREADY  out  1  address ready
- S_AXI_WDATA  in  DW  write data
- S_AXI_WSTRB  in  DW/8  byte strobes
- S_AXI_WLAST  in  1  last beat
- S_AXI_WVALID  in  1  data valid
- S_AXI_WREADY  out  1  data ready
- S_AXI_BRESP  out  2  OKAY=00, SLVERR=10
- S_AXI_BID  out  IW  echoed AWID
- S_AXI_BVALID  out  1  response valid
- S_AXI_BREADY  in  1  response ready
- AXIS_OUT_TDATA  out  DW  forwarded WDATA
- AXIS_OUT_TKEEP  out  DW/8  forwarded WSTRB
- AXIS_OUT_TUSER  out  AW+UW  {latched AWUSER, latched AWADDR}, constant for the whole burst
- AXIS_OUT_TLAST  out  1  final beat of burst, per AWLEN
- AXIS_OUT_TVALID  out  1  stream valid
- AXIS_OUT_TREADY  in  1  stream ready
- burst_error  out  1  sticky: set on any SLVERR; cleared only by reset

Behaviour:
- Reset values (resetn low at a clock edge): state=S_IDLE; AWREADY=0 in the reset cycle; BVALID=0; BRESP=0; burst_error=0; beat counter=0. No TVALID or WREADY while in S_IDLE.
- Reset mid-burst or mid-response: the burst is abandoned, no B is issued, and the state returns to S_IDLE.
- FSM states: S_IDLE, S_DATA, S_RESP.
- S_IDLE:
  - AWREADY=1 (registered; goes high the first cycle after reset deasserts).
  - On AWVALID&AWREADY: latch ADDR, USER, LEN, ID.
  - Latch err = (AWBURST!=INCR) | (AWSIZE!=log2(DW/8)).
  - beat=0 → S_DATA; AWREADY drops the next cycle.
- S_DATA:
  - Pass-through with zero latency: TVALID=WVALID, WREADY=TREADY, TDATA/TKEEP=WDATA/WSTRB.
  - TLAST=(beat==latched LEN), regardless of WLAST.
  - Each W handshake: beat+1.
  - If WLAST != (beat==LEN) on any accepted beat: set err.
  - On the handshake with beat==LEN → S_RESP.
  - An early WLAST does not end the burst; the block keeps consuming until LEN+1 beats.
- S_RESP:
  - BVALID=1, BID=latched ID, BRESP = err ? 2'b10 : 2'b00.
  - On BREADY → S_IDLE.
  - burst_error |= err on entering S_RESP.
- Single outstanding burst: AWREADY stays low from AW accept until the B handshake completes.
- Back-to-back: the next AW is accepted no earlier than the cycle after the B handshake.
- AWLEN=0: a single beat with TLAST=1.
- AWLEN=255: 256 beats; the beat counter is 8 bits and does not wrap before the final beat.
- Backpressure: TREADY low stalls W with no data loss, no duplicate beats, and stable TDATA.

Optional Feature:
- Macro: RDMX_RESPONDER_STATS_EN.
- When defined, three extra outputs are added:
  - bursts_rcvd (32 bits): +1 per B handshake.
  - beats_rcvd (48 bits): +1 per W handshake.
  - err_bursts (32 bits): +1 per SLVERR B handshake.
- All three counters reset to 0 and saturate at all-ones.
- When undefined, these ports and their logic do not exist; the remaining behaviour is unchanged.

Test Plan:
- AW addr=0x1000, LEN=3, ID=5, INCR, SIZE=6; 4 W beats with WLAST on beat 3; TREADY=1 → 4 stream beats, TLAST on the 4th only, TUSER addr=0x1000, BID=5, BRESP=00, burst_error=0.
- Same burst with WLAST on beat 1 → 4 beats still forwarded, TLAST on the 4th, BRESP=10, burst_error=1 and stays 1 across later good bursts.
- AWLEN=0 single beat, then an immediate second AW → first B completes before AWREADY reasserts; TLAST=1 on the single beat.
- AWLEN=255 with TREADY toggling randomly → exactly 256 beats, data order preserved, B issued once, BRESP=00.
- AWBURST=FIXED, LEN=1 → 2 beats forwarded, BRESP=10.
- Reset pulsed during S_DATA after beat 2 of LEN=7 → BVALID stays 0, AWREADY=1 in the first cycle after reset deasserts, and the next burst completes normally.

Source files
------------

// File: rtl/rdmx_write_responder_if.sv
// Bus bundle for rdmx_write_responder.
// Carries the AXI4 write channels (AW/W/B) and the AXI-Stream output toward the PCI receive path.
interface rdmx_write_responder_if #(
   parameter int unsigned DW = 512,
   parameter int unsigned AW = 64,
   parameter int unsigned IW = 4,
   parameter int unsigned UW = 32
);
   logic [AW-1:0]      S_AXI_AWADDR;
   logic [UW-1:0]      S_AXI_AWUSER;
   logic [7:0]         S_AXI_AWLEN;
   logic [2:0]         S_AXI_AWSIZE;
   logic [1:0]         S_AXI_AWBURST;
   logic [IW-1:0]      S_AXI_AWID;
   logic               S_AXI_AWVALID;
   logic               S_AXI_AWREADY;

   logic [DW-1:0]      S_AXI_WDATA;
   logic [DW/8-1:0]    S_AXI_WSTRB;
   logic               S_AXI_WLAST;
   logic               S_AXI_WVALID;
   logic               S_AXI_WREADY;

   logic [1:0]         S_AXI_BRESP;
   logic [IW-1:0]      S_AXI_BID;
   logic               S_AXI_BVALID;
   logic               S_AXI_BREADY;

   logic [DW-1:0]      AXIS_OUT_TDATA;
   logic [DW/8-1:0]    AXIS_OUT_TKEEP;
   logic [AW+UW-1:0]   AXIS_OUT_TUSER;
   logic               AXIS_OUT_TLAST;
   logic               AXIS_OUT_TVALID;
   logic               AXIS_OUT_TREADY;

   // Responder side: AXI4 write slave and stream source.
   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWUSER, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
      input  S_AXI_AWID, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BID, S_AXI_BVALID,
      input  S_AXI_BREADY,
      output AXIS_OUT_TDATA, AXIS_OUT_TKEEP, AXIS_OUT_TUSER, AXIS_OUT_TLAST, AXIS_OUT_TVALID,
      input  AXIS_OUT_TREADY
   );

   // Link side: AXI4 write master and stream sink.
   modport master (
      output S_AXI_AWADDR, S_AXI_AWUSER, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
      output S_AXI_AWID, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BID, S_AXI_BVALID,
      output S_AXI_BREADY,
      input  AXIS_OUT_TDATA, AXIS_OUT_TKEEP, AXIS_OUT_TUSER, AXIS_OUT_TLAST, AXIS_OUT_TVALID,
      output AXIS_OUT_TREADY
   );
endinterface

// File: rtl/rdmx_write_responder.sv
// RDMX receive-end AXI4 write slave: one burst at a time, W beats forwarded on AXI-Stream, then B.
// Optional traffic counters are built when RDMX_RESPONDER_STATS_EN is defined.
module rdmx_write_responder #(
   parameter int unsigned DW = 512,
   parameter int unsigned AW = 64,
   parameter int unsigned IW = 4,
   parameter int unsigned UW = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   rdmx_write_responder_if.slave io_bus,
   output logic                  burst_error
`ifdef RDMX_RESPONDER_STATS_EN
   ,
   output logic [31:0]           bursts_rcvd,
   output logic [47:0]           beats_rcvd,
   output logic [31:0]           err_bursts
`endif
);

   localparam logic [2:0] LP_SIZE   = 3'($clog2(DW / 8));
   localparam logic [1:0] LP_INCR   = 2'b01;
   localparam logic [1:0] LP_OKAY   = 2'b00;
   localparam logic [1:0] LP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_RESP
   } state_t;

   state_t          r_state;
   state_t          w_state_d;

   logic            r_awready;
   logic            w_awready_d;
   logic [AW-1:0]   r_addr;
   logic [UW-1:0]   r_user;
   logic [7:0]      r_len;
   logic [IW-1:0]   r_id;
   logic [7:0]      r_beat;
   logic            r_err;
   logic            r_burst_error;

   logic            w_aw_hs;
   logic            w_w_hs;
   logic            w_b_hs;
   logic            w_last_beat;
   logic            w_wlast_err;
   logic            w_aw_err;

   always_comb begin
      w_aw_hs     = (r_state == S_IDLE) & r_awready & io_bus.S_AXI_AWVALID;
      w_w_hs      = (r_state == S_DATA) & io_bus.S_AXI_WVALID & io_bus.AXIS_OUT_TREADY;
      w_b_hs      = (r_state == S_RESP) & io_bus.S_AXI_BREADY;
      w_last_beat = (r_beat == r_len);
      // WLAST must coincide exactly with the AWLEN-derived final beat.
      w_wlast_err = w_w_hs & (io_bus.S_AXI_WLAST != w_last_beat);
      w_aw_err    = (io_bus.S_AXI_AWBURST != LP_INCR) | (io_bus.S_AXI_AWSIZE != LP_SIZE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d                     = r_state;
      io_bus.S_AXI_WREADY           = 1'b0;
      io_bus.AXIS_OUT_TVALID        = 1'b0;
      io_bus.S_AXI_BVALID           = 1'b0;
      io_bus.S_AXI_BRESP            = LP_OKAY;
      unique case (r_state)
         S_IDLE: begin
            if (w_aw_hs) begin
               w_state_d = S_DATA;
            end
         end
         S_DATA: begin
            io_bus.S_AXI_WREADY    = io_bus.AXIS_OUT_TREADY;
            io_bus.AXIS_OUT_TVALID = io_bus.S_AXI_WVALID;
            if (w_w_hs && w_last_beat) begin
               w_state_d = S_RESP;
            end
         end
         S_RESP: begin
            io_bus.S_AXI_BVALID = 1'b1;
            io_bus.S_AXI_BRESP  = r_err ? LP_SLVERR : LP_OKAY;
            if (io_bus.S_AXI_BREADY) begin
               w_state_d = S_IDLE;
            end
         end
         default: begin
            w_state_d = S_IDLE;
         end
      endcase
      // AWREADY is registered and only offered while idle, so a new AW waits for the B handshake.
      w_awready_d = (w_state_d == S_IDLE);
   end

   always_comb begin
      io_bus.S_AXI_AWREADY  = r_awready;
      io_bus.S_AXI_BID      = r_id;
      io_bus.AXIS_OUT_TDATA = io_bus.S_AXI_WDATA;
      io_bus.AXIS_OUT_TKEEP = io_bus.S_AXI_WSTRB;
      io_bus.AXIS_OUT_TUSER = {r_user, r_addr};
      io_bus.AXIS_OUT_TLAST = w_last_beat;
      burst_error           = r_burst_error;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_awready     <= 1'b0;
         r_addr        <= '0;
         r_user        <= '0;
         r_len         <= '0;
         r_id          <= '0;
         r_beat        <= '0;
         r_err         <= 1'b0;
         r_burst_error <= 1'b0;
      end else begin
         r_awready <= w_awready_d;
         if (w_aw_hs) begin
            r_addr <= io_bus.S_AXI_AWADDR;
            r_user <= io_bus.S_AXI_AWUSER;
            r_len  <= io_bus.S_AXI_AWLEN;
            r_id   <= io_bus.S_AXI_AWID;
            r_beat <= '0;
            r_err  <= w_aw_err;
         end
         if (w_w_hs) begin
            r_beat <= r_beat + 8'd1;
            r_err  <= r_err | w_wlast_err;
            if (w_last_beat) begin
               r_burst_error <= r_burst_error | r_err | w_wlast_err;
            end
         end
      end
   end

`ifdef RDMX_RESPONDER_STATS_EN
   logic [31:0] r_bursts_rcvd;
   logic [47:0] r_beats_rcvd;
   logic [31:0] r_err_bursts;

   // Counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_bursts_rcvd <= '0;
         r_beats_rcvd  <= '0;
         r_err_bursts  <= '0;
      end else begin
         if (w_b_hs && (r_bursts_rcvd != '1)) begin
            r_bursts_rcvd <= r_bursts_rcvd + 32'd1;
         end
         if (w_b_hs && r_err && (r_err_bursts != '1)) begin
            r_err_bursts <= r_err_bursts + 32'd1;
         end
         if (w_w_hs && (r_beats_rcvd != '1)) begin
            r_beats_rcvd <= r_beats_rcvd + 48'd1;
         end
      end
   end

   assign bursts_rcvd = r_bursts_rcvd;
   assign beats_rcvd  = r_beats_rcvd;
   assign err_bursts  = r_err_bursts;
`else
   logic w_unused_b_hs;
   assign w_unused_b_hs = w_b_hs;
`endif

endmodule

// File: tb/tb_rdmx_write_responder.sv
// Directed self-checking bench for rdmx_write_responder.
// Table of bursts plus hand sequences for back-to-back AW and reset mid-burst.
module tb_rdmx_write_responder;

   localparam int unsigned DW = 512;
   localparam int unsigned AW = 64;
   localparam int unsigned IW = 4;
   localparam int unsigned UW = 32;

   typedef struct {
      logic [AW-1:0] addr;
      logic [UW-1:0] user;
      logic [7:0]    len;
      logic [IW-1:0] id;
      logic [1:0]    burst;
      logic [2:0]    size;
      int            wlast_at;
      bit            rnd;
      logic [1:0]    exp_resp;
   } vec_t;

   logic clk = 1'b0;
   logic resetn;
   logic burst_error;
   int   n_checks;
   int   n_fail;
   bit   exp_berr;

   always #5 clk = ~clk;

   rdmx_write_responder_if #(.DW(DW), .AW(AW), .IW(IW), .UW(UW)) u_if ();

`ifdef RDMX_RESPONDER_STATS_EN
   logic [31:0] bursts_rcvd;
   logic [47:0] beats_rcvd;
   logic [31:0] err_bursts;
   rdmx_write_responder #(.DW(DW), .AW(AW), .IW(IW), .UW(UW)) u_dut (
      .clk(clk), .resetn(resetn), .io_bus(u_if.slave), .burst_error(burst_error),
      .bursts_rcvd(bursts_rcvd), .beats_rcvd(beats_rcvd), .err_bursts(err_bursts)
   );
`else
   rdmx_write_responder #(.DW(DW), .AW(AW), .IW(IW), .UW(UW)) u_dut (
      .clk(clk), .resetn(resetn), .io_bus(u_if.slave), .burst_error(burst_error)
   );
`endif

   task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat(input int bno, input int k);
      logic [DW-1:0] d;
      for (int i = 0; i < int'(DW / 32); i++) begin
         d[i*32 +: 32] = 32'(bno * 32'h0101_0000) ^ 32'(k * 32'h0001_0003) ^ 32'(i * 32'h1111);
      end
      return d;
   endfunction

   function automatic logic [DW/8-1:0] strb(input int bno, input int k);
      return {2{32'(bno * 256 + k) ^ 32'hF0F0_0FF0}};
   endfunction

   task automatic set_aw(input vec_t v);
      u_if.S_AXI_AWADDR  = v.addr;
      u_if.S_AXI_AWUSER  = v.user;
      u_if.S_AXI_AWLEN   = v.len;
      u_if.S_AXI_AWID    = v.id;
      u_if.S_AXI_AWBURST = v.burst;
      u_if.S_AXI_AWSIZE  = v.size;
   endtask

   // Every task starts and ends just after a rising edge.
   task automatic do_aw(input vec_t v);
      int n  = 0;
      bit ok = 1'b0;
      set_aw(v);
      u_if.S_AXI_AWVALID = 1'b1;
      while (!ok && n < 20) begin
         @(negedge clk);
         if (u_if.S_AXI_AWREADY) ok = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      u_if.S_AXI_AWVALID = 1'b0;
      chk("aw_accept", ok, 1'b1);
   endtask

   task automatic do_w(input vec_t v, input int bno, input int nbeats);
      int   k   = 0;
      int   cyc = 0;
      logic tr;
      while (k < nbeats && cyc < 3000) begin
         tr = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         u_if.S_AXI_WVALID    = 1'b1;
         u_if.S_AXI_WDATA     = pat(bno, k);
         u_if.S_AXI_WSTRB     = strb(bno, k);
         u_if.S_AXI_WLAST     = (k == v.wlast_at);
         u_if.AXIS_OUT_TREADY = tr;
         @(negedge clk);
         chk("tvalid", u_if.AXIS_OUT_TVALID, 1'b1);
         chk("wready", u_if.S_AXI_WREADY, tr);
         chk("tdata", u_if.AXIS_OUT_TDATA, pat(bno, k));
         chk("tkeep", u_if.AXIS_OUT_TKEEP, strb(bno, k));
         chk("tlast", u_if.AXIS_OUT_TLAST, (k == int'(v.len)));
         chk("tuser", u_if.AXIS_OUT_TUSER, {v.user, v.addr});
         chk("awready_busy", u_if.S_AXI_AWREADY, 1'b0);
         @(posedge clk); #1;
         if (tr) k++;
         cyc++;
      end
      if (k < nbeats) chk("w_timeout", k, nbeats);
      u_if.S_AXI_WVALID    = 1'b0;
      u_if.S_AXI_WLAST     = 1'b0;
      u_if.AXIS_OUT_TREADY = 1'b1;
   endtask

   task automatic do_b(input vec_t v, input int hold);
      if (v.exp_resp == 2'b10) exp_berr = 1'b1;
      // Offer an extra W beat while responding; it must not be taken or forwarded.
      u_if.S_AXI_WVALID = 1'b1;
      u_if.S_AXI_WDATA  = pat(99, 99);
      for (int h = 0; h <= hold; h++) begin
         u_if.S_AXI_BREADY = (h == hold);
         @(negedge clk);
         chk("bvalid", u_if.S_AXI_BVALID, 1'b1);
         chk("bid", u_if.S_AXI_BID, v.id);
         chk("bresp", u_if.S_AXI_BRESP, v.exp_resp);
         chk("burst_error", burst_error, exp_berr);
         chk("awready_resp", u_if.S_AXI_AWREADY, 1'b0);
         chk("wready_resp", u_if.S_AXI_WREADY, 1'b0);
         chk("tvalid_resp", u_if.AXIS_OUT_TVALID, 1'b0);
         @(posedge clk); #1;
      end
      u_if.S_AXI_BREADY = 1'b0;
      u_if.S_AXI_WVALID = 1'b0;
      @(negedge clk);
      chk("bvalid_done", u_if.S_AXI_BVALID, 1'b0);
      chk("awready_after_b", u_if.S_AXI_AWREADY, 1'b1);
      chk("burst_error_hold", burst_error, exp_berr);
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs [7];
      vec_t b1, b2, r7, r2;
      vecs[0] = '{64'h1000, 32'hCAFE_0001, 8'd3, 4'd5, 2'b01, 3'd6, 3, 1'b0, 2'b00};
      vecs[1] = '{64'h1000, 32'hCAFE_0002, 8'd3, 4'd5, 2'b01, 3'd6, 1, 1'b0, 2'b10};
      vecs[2] = '{64'h2000, 32'h1234_5678, 8'd2, 4'd9, 2'b01, 3'd6, 2, 1'b1, 2'b00};
      vecs[3] = '{64'h3000, 32'h0000_0003, 8'd1, 4'd1, 2'b00, 3'd6, 1, 1'b0, 2'b10};
      vecs[4] = '{64'h4000, 32'h0000_0004, 8'd0, 4'd2, 2'b01, 3'd5, 0, 1'b0, 2'b10};
      vecs[5] = '{64'hDEAD_0000_0000_5000, 32'hBEEF_0005, 8'd255, 4'd7, 2'b01, 3'd6, 255,
                  1'b1, 2'b00};
      vecs[6] = '{64'h6000, 32'h0000_0006, 8'd2, 4'd12, 2'b01, 3'd6, -1, 1'b0, 2'b10};
      b1 = '{64'h7000, 32'h0000_0007, 8'd0, 4'd3, 2'b01, 3'd6, 0, 1'b0, 2'b00};
      b2 = '{64'h8000, 32'h0000_0008, 8'd0, 4'd10, 2'b01, 3'd6, 0, 1'b0, 2'b00};
      r7 = '{64'h9000, 32'h0000_0009, 8'd7, 4'd4, 2'b01, 3'd6, 7, 1'b0, 2'b00};
      r2 = '{64'hA000, 32'h0000_000A, 8'd2, 4'd6, 2'b01, 3'd6, 2, 1'b0, 2'b00};

      n_checks = 0;
      n_fail   = 0;
      exp_berr = 1'b0;
      resetn   = 1'b0;
      set_aw(b1);
      u_if.S_AXI_AWVALID   = 1'b0;
      u_if.S_AXI_WDATA     = '0;
      u_if.S_AXI_WSTRB     = '0;
      u_if.S_AXI_WLAST     = 1'b0;
      u_if.S_AXI_WVALID    = 1'b1;
      u_if.S_AXI_BREADY    = 1'b0;
      u_if.AXIS_OUT_TREADY = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_awready", u_if.S_AXI_AWREADY, 1'b0);
      chk("rst_bvalid", u_if.S_AXI_BVALID, 1'b0);
      chk("rst_bresp", u_if.S_AXI_BRESP, 2'b00);
      chk("rst_burst_error", burst_error, 1'b0);
      chk("rst_tvalid", u_if.AXIS_OUT_TVALID, 1'b0);
      chk("rst_wready", u_if.S_AXI_WREADY, 1'b0);
      @(posedge clk); #1;
      u_if.S_AXI_WVALID = 1'b0;
      resetn = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("awready_out_of_reset", u_if.S_AXI_AWREADY, 1'b1);
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         do_aw(vecs[i]);
         do_w(vecs[i], i, int'(vecs[i].len) + 1);
         do_b(vecs[i], i % 3);
      end

      // Back-to-back: second AW held valid during the first B phase.
      do_aw(b1);
      do_w(b1, 20, 1);
      set_aw(b2);
      u_if.S_AXI_AWVALID = 1'b1;
      do_b(b1, 2);
      u_if.S_AXI_AWVALID = 1'b0;
      @(negedge clk);
      chk("b2b_awready_drop", u_if.S_AXI_AWREADY, 1'b0);
      @(posedge clk); #1;
      do_w(b2, 21, 1);
      do_b(b2, 0);

      // Reset after three beats of an eight-beat burst.
      do_aw(r7);
      do_w(r7, 30, 3);
      resetn = 1'b0;
      u_if.S_AXI_WVALID = 1'b1;
      u_if.S_AXI_BREADY = 1'b1;
      @(posedge clk); #1;
      resetn   = 1'b1;
      exp_berr = 1'b0;
      @(negedge clk);
      chk("mid_rst_bvalid", u_if.S_AXI_BVALID, 1'b0);
      chk("mid_rst_awready", u_if.S_AXI_AWREADY, 1'b0);
      chk("mid_rst_tvalid", u_if.AXIS_OUT_TVALID, 1'b0);
      chk("mid_rst_burst_error", burst_error, 1'b0);
      @(posedge clk); #1;
      u_if.S_AXI_WVALID = 1'b0;
      u_if.S_AXI_BREADY = 1'b0;
      @(negedge clk);
      chk("post_rst_awready", u_if.S_AXI_AWREADY, 1'b1);
      chk("post_rst_bvalid", u_if.S_AXI_BVALID, 1'b0);
      @(posedge clk); #1;
      do_aw(r2);
      do_w(r2, 31, 3);
      do_b(r2, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
